serial_adder_ctrl: RTL and testbench

Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in with one shared one-bit `full_adder`, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. It is the sequencing layer above the team's combinational `full_adder` cell and trades WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_if.sv | 37 +++
 rtl/full_adder.sv | 17 +
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types for the bit-serial adder controller.
// State encoding; 2'd3 is unused and recovers to IDLE.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done bundle of the serial adder.
// master = requester, slave = adder. ovf exists with SERIAL_ADDER_OVF_EN.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, c_in,
    input  ready, done, sum,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output ready, done, sum,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output c_out
  );

endinterface

// File: rtl/full_adder.sv
// full_adder: combinational one-bit full adder cell.
// Ports: A, B, C_in in; S, C_out out.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  logic p;

  assign p     = A ^ B;
  assign S     = p ^ C_in;
  assign C_out = (A & B) | (C_in & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds a+b+c_in LSB first through one full_adder.
// Ports: clk, rst_n, bus (slave). Optional ovf: SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_n;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic             last;
  logic             load;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .A     (op_a[0]),
    .B     (op_b[0]),
    .C_in  (carry),
    .S     (fa_s),
    .C_out (fa_co)
  );

  assign last = (cnt == LAST);
  assign load = (state == IDLE) && bus.start;

  // New sum bit enters at the MSB; the LSB falls off.
  if (WIDTH == 1) begin : g_sum1
    assign sum_n = fa_s;
  end else begin : g_sumn
    assign sum_n = {fa_s, sum_q[WIDTH-1:1]};
  end

  // Ripple incrementer for the bit counter.
  always_comb begin
    logic c;
    cnt_n = '0;
    c     = 1'b1;
    for (int i = 0; i < CW; i++) begin
      cnt_n[i] = cnt[i] ^ c;
      c        = cnt[i] & c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = IDLE;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        bus.ready = 1'b1;
        state_n   = bus.start ? RUN : IDLE;
      end
      (state == RUN): begin
        state_n = last ? DONE : RUN;
      end
      (state == DONE): begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      sum_q <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      op_a  <= bus.a;
      op_b  <= bus.b;
      carry <= bus.c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      sum_q <= sum_n;
      carry <= fa_co;
      cnt   <= cnt_n;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = carry;

`ifdef SERIAL_ADDER_OVF_EN
  logic c_msb;

  // On the last bit, carry still holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_msb <= 1'b0;
    end else if (state == RUN && last) begin
      c_msb <= carry;
    end
  end

  assign bus.ovf = c_msb ^ carry;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: random and directed checks of serial_adder_ctrl.
// Reference: integer a+b+c_in and a sign-based overflow rule.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_ovf(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] s
  );
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // inject_at >= 0: start with AA/55 after that many RUN edges.
  // noise: random start/operands while the op runs.
  task automatic run_op(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci,
    input int           inject_at,
    input bit           noise,
    input string        tag
  );
    logic [W:0]   r;
    logic [W-1:0] s_exp;
    int           cyc;
    bit           seen;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s_exp = r[W-1:0];
    @(negedge clk);
    expect_eq({tag, ".ready"}, 64'(bus.ready), 64'd1);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = ci;
    @(negedge clk);
    bus.start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < W + 4) begin
      bus.a    = W'($urandom);
      bus.b    = W'($urandom);
      bus.c_in = 1'($urandom);
      bus.start = noise ? 1'($urandom) : 1'b0;
      if (cyc == inject_at) begin
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
      end
      @(negedge clk);
      cyc++;
      seen = bus.done;
    end
    bus.start = 1'b0;
    expect_eq({tag, ".lat"}, seen ? 64'(cyc) : 64'd0, 64'(W));
    if (seen) begin
      expect_eq({tag, ".sum"}, 64'(bus.sum), 64'(s_exp));
      expect_eq({tag, ".cout"}, 64'(bus.c_out), 64'(r[W]));
`ifdef SERIAL_ADDER_OVF_EN
      expect_eq({tag, ".ovf"}, 64'(bus.ovf),
                64'(ref_ovf(a, b, s_exp)));
`endif
      @(negedge clk);
      expect_eq({tag, ".pulse"}, 64'(bus.done), 64'd0);
      expect_eq({tag, ".idle"}, 64'(bus.ready), 64'd1);
      expect_eq({tag, ".hold"}, 64'({bus.c_out, bus.sum}), 64'(r));
    end
  endtask

  initial begin
    int dones;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    rst_n     = 1'b0;
    #3;
    expect_eq("rst.ready", 64'(bus.ready), 64'd1);
    expect_eq("rst.done", 64'(bus.done), 64'd0);
    expect_eq("rst.sum", 64'(bus.sum), 64'd0);
    expect_eq("rst.cout", 64'(bus.c_out), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    expect_eq("rst.ovf", 64'(bus.ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, -1, 1'b0, "basic");
    run_op(8'hFF, 8'hFF, 1'b1, -1, 1'b0, "ripple");
    run_op(8'h7F, 8'h01, 1'b0, -1, 1'b0, "ovf");
    run_op(8'hFF, 8'h01, 1'b0, -1, 1'b0, "wrap");
    run_op(8'h10, 8'h20, 1'b0, 2, 1'b0, "ignore");

    // Abort mid-op: reset between edges, then no done may follow.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hC3;
    bus.b     = 8'h5A;
    bus.c_in  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("abort.ready", 64'(bus.ready), 64'd1);
    expect_eq("abort.done", 64'(bus.done), 64'd0);
    expect_eq("abort.sum", 64'(bus.sum), 64'd0);
    expect_eq("abort.cout", 64'(bus.c_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    expect_eq("abort.nodone", 64'(dones), 64'd0);
    run_op(8'h01, 8'h01, 1'b0, -1, 1'b0, "after");

    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             -1, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
